// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the instruction/data memory arbiter.
//   state_t  - arbiter FSM states (IDLE, CMD, RESP, DONE)
//   owner_t  - which requester owns the current access (IM, DM)
//   ADDR_W   - unified memory word-address width
//   DATA_W   - memory data width
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        IM = 1'b0,
        DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between the two requesters.
//   im_req     in  instruction-fetch request
//   dm_req     in  data request
//   last_owner in  port granted most recently; the other port wins a tie
//   winner     out selected port (only meaningful when a request is present)
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   im_req,
    input  logic   dm_req,
    input  owner_t last_owner,
    output owner_t winner
);

    always_comb begin
        winner = DM;
        if (im_req && dm_req) begin
            winner = (last_owner == IM) ? DM : IM;
        end else if (im_req) begin
            winner = IM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory between an instruction-fetch port
// (IM) and a data port (DM). Each access runs IDLE -> CMD -> RESP -> DONE.
//   clk, rst                        clock, synchronous active-high reset
//   im_req, im_addr                 fetch request / word address
//   im_done, im_rdata               fetch completion pulse / fetch data
//   dm_req, dm_we, dm_addr, dm_wdata data request / write enable / address / data
//   dm_done, dm_rdata               data completion pulse / read data
//   mem_enable, mem_read, mem_write unified memory strobes (CMD cycle only)
//   mem_address, mem_in             memory address / write data
//   mem_out                         memory read data, valid the cycle after a read
//   busy                            high whenever the FSM is not in IDLE
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise DM always wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IM_BASE = 12'h000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_req,
    input  logic [9:0]        im_addr,
    output logic              im_done,
    output logic [DATA_W-1:0] im_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_enable,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    state_t            state;
    owner_t            owner;
    owner_t            winner;
    owner_t            pick_last;
    logic              is_write;
    logic [ADDR_W-1:0] im_full_addr;

    // Sum truncated to ADDR_W bits, so the fetch address wraps modulo 4096.
    assign im_full_addr = IM_BASE + {2'b00, im_addr};

`ifdef MEM_ARBITER_RR_EN
    owner_t last_grant;
    assign pick_last = last_grant;
`else
    // Pretending IM was granted last makes the picker always favour DM.
    assign pick_last = IM;
`endif

    mem_arb_pick u_pick (
        .im_req     (im_req),
        .dm_req     (dm_req),
        .last_owner (pick_last),
        .winner     (winner)
    );

    // Outputs are registered: the strobes are loaded on the edge that enters
    // CMD so they are valid for exactly the CMD cycle, and the done pulse is
    // loaded on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= DM;
            is_write    <= 1'b0;
            busy        <= 1'b0;
            im_done     <= 1'b0;
            dm_done     <= 1'b0;
            im_rdata    <= '0;
            dm_rdata    <= '0;
            mem_enable  <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_in      <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_grant  <= IM;
`endif
        end else begin
            im_done     <= 1'b0;
            dm_done     <= 1'b0;
            mem_enable  <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_in      <= '0;

            case (state)
                IDLE: begin
                    if (im_req || dm_req) begin
                        state      <= CMD;
                        busy       <= 1'b1;
                        owner      <= winner;
                        mem_enable <= 1'b1;
`ifdef MEM_ARBITER_RR_EN
                        last_grant <= winner;
`endif
                        if (winner == IM) begin
                            is_write    <= 1'b0;
                            mem_read    <= 1'b1;
                            mem_address <= im_full_addr;
                        end else begin
                            is_write    <= dm_we;
                            mem_read    <= ~dm_we;
                            mem_write   <= dm_we;
                            mem_address <= dm_addr;
                            mem_in      <= dm_we ? dm_wdata : '0;
                        end
                    end
                end

                CMD: begin
                    state <= RESP;
                end

                RESP: begin
                    state <= DONE;
                    if (owner == IM) begin
                        im_rdata <= mem_out;
                        im_done  <= 1'b1;
                    end else begin
                        if (!is_write) begin
                            dm_rdata <= mem_out;
                        end
                        dm_done <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter. A second
// instance with IM_BASE = 12'hF00 shares the inputs to exercise address wrap.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        im_req = 1'b0;
    logic [9:0]  im_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [11:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] mem_out = '0;

    logic        im_done, dm_done, mem_enable, mem_read, mem_write, busy;
    logic [31:0] im_rdata, dm_rdata, mem_in;
    logic [11:0] mem_address;

    logic        w_im_done, w_dm_done, w_mem_enable, w_mem_read, w_mem_write, w_busy;
    logic [31:0] w_im_rdata, w_dm_rdata, w_mem_in;
    logic [11:0] w_mem_address;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.IM_BASE(12'h000)) dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_done(im_done), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out), .busy(busy)
    );

    mem_arbiter #(.IM_BASE(12'hF00)) dut_w (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_done(w_im_done), .im_rdata(w_im_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(w_dm_done), .dm_rdata(w_dm_rdata),
        .mem_enable(w_mem_enable), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .mem_address(w_mem_address), .mem_in(w_mem_in), .mem_out(mem_out), .busy(w_busy)
    );

    typedef struct {
        logic        im_req;
        logic        dm_req;
        logic        dm_we;
        logic [9:0]  im_addr;
        logic [11:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] mem_data;
        logic [11:0] exp_addr;
        logic [11:0] exp_waddr;
        logic [31:0] exp_im_rd;
        logic [31:0] exp_dm_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        logic is_im;
        logic is_wr;
        is_im = v.im_req && !v.dm_req;
        is_wr = !is_im && v.dm_we;
        @(negedge clk);
        im_req   = v.im_req;
        dm_req   = v.dm_req;
        dm_we    = v.dm_we;
        im_addr  = v.im_addr;
        dm_addr  = v.dm_addr;
        dm_wdata = v.dm_wdata;
        // CMD cycle
        @(negedge clk);
        check($sformatf("v%0d cmd mem_enable", idx), 32'(mem_enable), 32'd1);
        check($sformatf("v%0d cmd mem_read", idx), 32'(mem_read), 32'(!is_wr));
        check($sformatf("v%0d cmd mem_write", idx), 32'(mem_write), 32'(is_wr));
        check($sformatf("v%0d cmd mem_address", idx), 32'(mem_address), 32'(v.exp_addr));
        check($sformatf("v%0d cmd mem_in", idx), mem_in, is_wr ? v.dm_wdata : 32'h0);
        check($sformatf("v%0d cmd wrap mem_address", idx), 32'(w_mem_address), 32'(v.exp_waddr));
        check($sformatf("v%0d cmd busy", idx), 32'(busy), 32'd1);
        // RESP cycle
        @(negedge clk);
        check($sformatf("v%0d resp strobes", idx),
              {29'd0, mem_enable, mem_read, mem_write}, 32'd0);
        check($sformatf("v%0d resp mem_in", idx), mem_in, 32'h0);
        check($sformatf("v%0d resp dones", idx), {30'd0, im_done, dm_done}, 32'd0);
        mem_out = v.mem_data;
        // DONE cycle: requester drops req while done is high
        @(negedge clk);
        check($sformatf("v%0d done im_done", idx), 32'(im_done), 32'(is_im));
        check($sformatf("v%0d done dm_done", idx), 32'(dm_done), 32'(!is_im));
        check($sformatf("v%0d im_rdata", idx), im_rdata, v.exp_im_rd);
        check($sformatf("v%0d dm_rdata", idx), dm_rdata, v.exp_dm_rd);
        im_req  = 1'b0;
        dm_req  = 1'b0;
        mem_out = '0;
        // back in IDLE
        @(negedge clk);
        check($sformatf("v%0d idle busy", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d idle dones", idx), {30'd0, im_done, dm_done}, 32'd0);
    endtask

    initial begin
        logic got[3];
        logic exp_order[3];
        int   n;

        //        im dm we im_addr  dm_addr  dm_wdata      mem_data      addr     waddr    im_rd         dm_rd
        vecs[0] = '{1, 0, 0, 10'h005, 12'h000, 32'h0,        32'hDEADBEEF, 12'h005, 12'hF05, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 1, 1, 10'h000, 12'h100, 32'h12345678, 32'hAAAA5555, 12'h100, 12'h100, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{0, 1, 0, 10'h000, 12'h0FF, 32'h0,        32'hCAFEF00D, 12'h0FF, 12'h0FF, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1, 0, 0, 10'h180, 12'h000, 32'h0,        32'h0BADF00D, 12'h180, 12'h080, 32'h0BADF00D, 32'hCAFEF00D};
        vecs[4] = '{1, 0, 0, 10'h3FF, 12'h000, 32'h0,        32'h76543210, 12'h3FF, 12'h2FF, 32'h76543210, 32'hCAFEF00D};
        vecs[5] = '{0, 1, 1, 10'h000, 12'hFFF, 32'hFFFFFFFF, 32'h11111111, 12'hFFF, 12'hFFF, 32'h76543210, 32'hCAFEF00D};
        vecs[6] = '{0, 1, 0, 10'h000, 12'h000, 32'h0,        32'h00000001, 12'h000, 12'h000, 32'h76543210, 32'h00000001};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset strobes", {29'd0, mem_enable, mem_read, mem_write}, 32'd0);
        check("reset mem_address", 32'(mem_address), 32'd0);
        check("reset mem_in", mem_in, 32'd0);
        check("reset dones", {30'd0, im_done, dm_done}, 32'd0);
        check("reset im_rdata", im_rdata, 32'd0);
        check("reset dm_rdata", dm_rdata, 32'd0);

        // Contention straight after reset: both requests held for 3 grants
`ifdef MEM_ARBITER_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b1};
`endif
        im_req  = 1'b1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        im_addr = 10'h001;
        dm_addr = 12'h002;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            check("contention no double done", 32'(im_done && dm_done), 32'd0);
            if (im_done || dm_done) begin
                got[n] = dm_done;
                n++;
                if (n == 3) begin
                    im_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        check("contention done count", 32'(n), 32'd3);
        for (int i = 0; i < 3 && i < n; i++) begin
            check($sformatf("contention grant%0d is_dm", i), 32'(got[i]), 32'(exp_order[i]));
        end
        im_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        check("contention idle busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Reset rdata registers so the table starts from a known state
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn(i, vecs[i]);
        end

        // Reset while in RESP: no done pulse, rdata cleared, back to idle
        @(negedge clk);
        im_req  = 1'b1;
        im_addr = 10'h010;
        @(negedge clk);                 // CMD
        @(negedge clk);                 // RESP
        check("rstresp busy before", 32'(busy), 32'd1);
        mem_out = 32'h55AA55AA;
        rst     = 1'b1;
        im_req  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rstresp busy", 32'(busy), 32'd0);
        check("rstresp im_rdata", im_rdata, 32'd0);
        check("rstresp dm_rdata", dm_rdata, 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("rstresp no done", {30'd0, im_done, dm_done}, 32'd0);
            check("rstresp stays idle", 32'(busy), 32'd0);
            @(negedge clk);
        end
        mem_out = '0;

        // Request dropped in CMD: transaction still completes
        im_req  = 1'b1;
        im_addr = 10'h020;
        @(negedge clk);                 // CMD
        check("drop cmd mem_address", 32'(mem_address), 32'h020);
        im_req = 1'b0;
        @(negedge clk);                 // RESP
        mem_out = 32'h13579BDF;
        @(negedge clk);                 // DONE
        check("drop im_done", 32'(im_done), 32'd1);
        check("drop im_rdata", im_rdata, 32'h13579BDF);
        mem_out = '0;
        @(negedge clk);
        check("drop idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("drop no regrant busy", 32'(busy), 32'd0);
        check("drop no regrant enable", 32'(mem_enable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
